// File: rtl/write_register_bank.sv
// Eight-entry, 32-bit write-only register bank with per-byte write enables
// and a sequenced clear. A clear request walks registers 0..7, one per
// cycle, loading RESET_VAL; writes are dropped while the walk is running.
// Register contents leave the block directly from flops for the downstream
// read mux.

module write_register_bank #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [2:0]  wAddr,
    input  logic [31:0] wData,
    input  logic [3:0]  wBe,
    input  logic        clr,
    output logic        busy,
    output logic [31:0] reg0,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic [31:0] reg3,
    output logic [31:0] reg4,
    output logic [31:0] reg5,
    output logic [31:0] reg6,
    output logic [31:0] reg7
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] regs [8];

    // Control FSM and register storage share one clocked process so that a
    // clear step and a write can never both target the array on one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            // NOTE: the register array sits in the reset branch on purpose;
            // these are architectural registers that must read RESET_VAL
            // straight after reset, not a RAM whose contents may be undefined.
            for (int n = 0; n < 8; n++) begin
                regs[n] <= RESET_VAL;
            end
        end else begin
            // NOTE: every state variable here uses <= so all updates on this
            // edge see the pre-edge values of state, cnt and regs.
            case (state)
                IDLE: begin
                    if (clr) begin
                        // clr wins over a simultaneous write; nothing is loaded
                        // on the entry edge.
                        state <= CLEAR;
                        cnt   <= 3'd0;
                    end else if (we) begin
                        for (int i = 0; i < 4; i++) begin
                            if (wBe[i]) begin
                                regs[wAddr][8*i +: 8] <= wData[8*i +: 8];
                            end
                        end
                    end
                end
                CLEAR: begin
                    // One register per edge; we and clr are ignored here.
                    regs[cnt] <= RESET_VAL;
                    cnt       <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= IDLE;
                    end
                end
                // NOTE: the default arm keeps the decode total so no stray
                // encoding can leave state undriven.
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // busy is a pure decode of the state flop.
    assign busy = (state == CLEAR);

    // Register outputs come straight from the storage flops.
    assign reg0 = regs[0];
    assign reg1 = regs[1];
    assign reg2 = regs[2];
    assign reg3 = regs[3];
    assign reg4 = regs[4];
    assign reg5 = regs[5];
    assign reg6 = regs[6];
    assign reg7 = regs[7];

endmodule

// File: doc/write_register_bank.md
WRITE_REGISTER_BANK -- requirements
Module: write_register_bank

Interface
REQ-001 SHALL have parameter RESET_VAL, default 32'h0000_0000: the value every register takes on reset and on a clear sequence.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port we  input  1  write enable, sampled on the rising clk edge.
REQ-005 SHALL have port wAddr  input  3  write address, selects register 0..7.
REQ-006 SHALL have port wData  input  32  write data.
REQ-007 SHALL have port wBe  input  4  byte enables; bit i qualifies wData[8i+7:8i].
REQ-008 SHALL have port clr  input  1  request to start a clear sequence.
REQ-009 SHALL have port busy  output  1  high while a clear sequence is running.
REQ-010 SHALL have ports reg0..reg7  output  32 each  register contents, driven straight from flops, for the downstream read mux's from_reg0..from_reg7.

Function
REQ-011 SHALL hold eight 32-bit registers, each driven onto its own output regN.
REQ-012 SHALL write on a rising edge where we=1, the FSM is IDLE, and clr=0: register[wAddr] byte i takes wData byte i for each i with wBe[i]=1; other bytes are unchanged.
REQ-013 SHALL make written data visible on regN one cycle after the write edge; there is no combinational write-to-output path.
REQ-014 SHALL leave all registers unchanged when we=1 with wBe=4'b0000.
REQ-015 SHALL implement an FSM with states IDLE and CLEAR, plus a 3-bit clear counter cnt.
REQ-016 SHALL, in IDLE with clr=1 on a rising edge, enter CLEAR with cnt=0 and load no register on that edge.
REQ-017 SHALL, in CLEAR, load register[cnt] with RESET_VAL on each edge and increment cnt.
REQ-018 SHALL, on the edge where cnt=7, clear register 7, wrap cnt to 0, and return to IDLE, so CLEAR lasts exactly 8 cycles.
REQ-019 SHALL drive busy=1 exactly while the state is CLEAR, decoded from state flops.
REQ-020 SHALL ignore we (drop the write, no effect) on every edge where the state is CLEAR.
REQ-021 SHALL ignore clr while in CLEAR; it does not restart the sequence or extend busy.
REQ-022 SHALL give clr priority when clr=1 and we=1 arrive together in IDLE: the write is dropped and CLEAR is entered.
REQ-023 SHALL accept a write on the first edge after busy falls (state IDLE).
REQ-024 SHALL give back-to-back writes to the same address last-write-wins, per byte.

Reset
REQ-025 SHALL, on reset_n=0 and regardless of clk, set all eight registers to RESET_VAL, state to IDLE, cnt to 0, and busy to 0.
REQ-026 SHALL, on reset asserted mid-CLEAR, abort the sequence; after reset_n rises, the block is IDLE with all registers at RESET_VAL.
REQ-027 SHALL take the first write on the first rising edge after reset_n has deasserted.

Verification
REQ-028 SHALL be covered by a bench running: reset, then write 32'h0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000 with wBe=4'hF to addresses 0..7 -> reg0..reg7 hold those values one cycle after each write.
REQ-029 SHALL be covered by a bench running: reg3=32'hFFFF_FFFF, write wData=32'h1234_5678 with wBe=4'b0101 -> reg3=32'hFF34_FF78.
REQ-030 SHALL be covered by a bench running: pulse clr -> busy=1 for exactly 8 cycles; registers 0..7 read RESET_VAL in ascending order, one per cycle; a write issued during busy leaves its target unchanged.
REQ-031 SHALL be covered by a bench running: clr=1 and we=1 (wAddr=2, wData=32'hDEAD_BEEF) on the same edge -> reg2 is not written and busy rises.
REQ-032 SHALL be covered by a bench running: reset_n pulsed low asynchronously (between clk edges) during cycle 4 of CLEAR -> busy=0 and all regN=RESET_VAL immediately; a write on the next edge is accepted.
REQ-033 SHALL be covered by a bench running: we=1 with wBe=0 -> no register changes.
